// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared encodings and helpers for the multi-channel NCO
package nco_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEL_STEP   = 2'd0,
        SEL_OFFSET = 2'd1,
        SEL_MODE   = 2'd2,
        SEL_RSVD   = 2'd3
    } cfg_sel_e;

    // Offset-binary zero level of a dac_w-bit converter.
    function automatic int midscale(input int dac_w);
        return 1 << (dac_w - 1);
    endfunction

endpackage

// File: rtl/nco_multi_if.sv
// rtl/nco_multi_if.sv - control/config inputs and DAC outputs of the multi-channel NCO
interface nco_multi_if #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 20,
    parameter int DAC_W    = 10
);
    logic                      i_en;
    logic                      i_sync;
    logic                      i_cfg_we;
    logic [2:0]                i_cfg_ch;
    logic [1:0]                i_cfg_sel;
    logic [ACC_W-1:0]          i_cfg_data;
    logic [CHANNELS*DAC_W-1:0] o_dac;
    logic [CHANNELS-1:0]       o_wrap;

    modport master (
        output i_en, i_sync, i_cfg_we, i_cfg_ch, i_cfg_sel, i_cfg_data,
        input  o_dac, o_wrap
    );

    modport slave (
        input  i_en, i_sync, i_cfg_we, i_cfg_ch, i_cfg_sel, i_cfg_data,
        output o_dac, o_wrap
    );
endinterface

// File: rtl/nco_sine_lut.sv
// rtl/nco_sine_lut.sv - quarter-wave sine magnitude ROM, one cycle read latency
module nco_sine_lut #(
    parameter int PH_W  = 12,
    parameter int DAC_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [PH_W-3:0]   i_addr,
    output logic [DAC_W-2:0]  o_mag
);
    localparam int DEPTH = 2 ** (PH_W - 2);

    // Samples at bin centres so quadrant mirroring needs no duplicate endpoint.
    function automatic logic [DAC_W-2:0] mag_at(input int k);
        real amp;
        real ang;
        int  v;
        amp = real'((2 ** (DAC_W - 1)) - 1);
        ang = 1.5707963267948966 * (real'(k) + 0.5) / real'(DEPTH);
        v   = $rtoi(amp * $sin(ang) + 0.5);
        return (DAC_W-1)'(v);
    endfunction

    logic [DAC_W-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DAC_W-2:0] MAG = mag_at(k);
        assign rom[k] = MAG;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mag <= '0;
        end else begin
            o_mag <= rom[i_addr];
        end
    end
endmodule

// File: rtl/nco_multi.sv
// rtl/nco_multi.sv - multi-channel NCO: per-channel accumulator, phase offset and waveform
// select feeding a 3-stage phase-to-amplitude pipeline.
module nco_multi
    import nco_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 20,
    parameter int PH_W     = 12,
    parameter int DAC_W    = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    nco_multi_if.slave  bus
);
    localparam logic [DAC_W-1:0] MID    = DAC_W'(midscale(DAC_W));
    localparam logic [DAC_W-1:0] MID_M1 = MID - DAC_W'(1);

    logic cfg_valid;
    assign cfg_valid = bus.i_cfg_we && (int'(bus.i_cfg_ch) < CHANNELS)
                    && (cfg_sel_e'(bus.i_cfg_sel) != SEL_RSVD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d, step_q, step_d, shadow_q, shadow_d;
        logic [ACC_W:0]   sum;
        logic [PH_W-1:0]  offset_q, offset_d;
        mode_e            mode_q, mode_d;
        logic             wrap_q, wrap_d;
        logic             sel_me;

        logic [PH_W-1:0]  phase;
        logic [PH_W-3:0]  lut_addr;
        logic [PH_W-3:0]  s1_addr_q;
        logic [DAC_W:0]   s1_ph_q, s2_ph_q;
        mode_e            s1_mode_q, s2_mode_q;
        logic             s1_wrap_q, s2_wrap_q, s3_wrap_q;
        logic [DAC_W-2:0] s2_mag;
        logic [DAC_W-1:0] mag_ext, tri_t, dac_d, dac_q;

        assign sel_me = cfg_valid && (int'(bus.i_cfg_ch) == c);

        // Step changes go through the shadow and only reach the accumulator at a
        // phase wrap, a sync, or while halted, so a running waveform never kinks.
        always_comb begin
            shadow_d = shadow_q;
            offset_d = offset_q;
            mode_d   = mode_q;
            if (sel_me) begin
                case (cfg_sel_e'(bus.i_cfg_sel))
                    SEL_STEP:   shadow_d = bus.i_cfg_data;
                    SEL_OFFSET: offset_d = bus.i_cfg_data[PH_W-1:0];
                    SEL_MODE:   mode_d   = mode_e'(bus.i_cfg_data[1:0]);
                    default:    ;
                endcase
            end

            sum    = {1'b0, acc_q} + {1'b0, step_q};
            acc_d  = acc_q;
            step_d = step_q;
            wrap_d = 1'b0;
            if (bus.i_sync) begin
                acc_d  = '0;
                step_d = shadow_d;
            end else if (bus.i_en) begin
                acc_d = sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    wrap_d = 1'b1;
                    step_d = shadow_d;
                end
            end else begin
                step_d = shadow_d;
            end
        end

        assign phase    = acc_q[ACC_W-1 -: PH_W] + offset_q;
        assign lut_addr = phase[PH_W-2] ? ~phase[PH_W-3:0] : phase[PH_W-3:0];

        nco_sine_lut #(.PH_W(PH_W), .DAC_W(DAC_W)) u_lut (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_addr  (s1_addr_q),
            .o_mag   (s2_mag)
        );

        // s2_ph_q[DAC_W] is the phase MSB: upper half of the cycle for every mode.
        assign mag_ext = {1'b0, s2_mag};
        assign tri_t   = s2_ph_q[DAC_W-1:0];

        always_comb begin
            dac_d = MID;
            case (s2_mode_q)
                MODE_SINE:   dac_d = s2_ph_q[DAC_W] ? (MID_M1 - mag_ext) : (MID + mag_ext);
                MODE_SQUARE: dac_d = s2_ph_q[DAC_W] ? '1 : '0;
                MODE_SAW:    dac_d = s2_ph_q[DAC_W -: DAC_W];
                MODE_TRI:    dac_d = s2_ph_q[DAC_W] ? ~tri_t : tri_t;
                default:     dac_d = MID;
            endcase
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                acc_q     <= '0;
                step_q    <= '0;
                shadow_q  <= '0;
                offset_q  <= '0;
                mode_q    <= MODE_SINE;
                wrap_q    <= 1'b0;
                s1_addr_q <= '0;
                s1_ph_q   <= '0;
                s1_mode_q <= MODE_SINE;
                s1_wrap_q <= 1'b0;
                s2_ph_q   <= '0;
                s2_mode_q <= MODE_SINE;
                s2_wrap_q <= 1'b0;
                dac_q     <= MID;
                s3_wrap_q <= 1'b0;
            end else begin
                acc_q     <= acc_d;
                step_q    <= step_d;
                shadow_q  <= shadow_d;
                offset_q  <= offset_d;
                mode_q    <= mode_d;
                wrap_q    <= wrap_d;
                s1_addr_q <= lut_addr;
                s1_ph_q   <= phase[PH_W-1 -: DAC_W+1];
                s1_mode_q <= mode_q;
                s1_wrap_q <= wrap_q;
                s2_ph_q   <= s1_ph_q;
                s2_mode_q <= s1_mode_q;
                s2_wrap_q <= s1_wrap_q;
                dac_q     <= dac_d;
                s3_wrap_q <= s2_wrap_q;
            end
        end

        assign bus.o_dac[c*DAC_W +: DAC_W] = dac_q;
        assign bus.o_wrap[c]               = s3_wrap_q;
    end
endmodule
